// File: rtl/eq_i2s_pkg.sv
// Shared definitions for the equalizer I2S output path: FSM encoding and frame geometry.
package eq_i2s_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_DATA_BITS = 16;

    // A stereo frame carries two slots of one sample width each.
    function automatic int frame_bits(input int data_bits);
        return 2 * data_bits;
    endfunction

    localparam int FRAME_BITS = frame_bits(DEF_DATA_BITS);

endpackage

// File: rtl/eq_sample_fifo.sv
// Small synchronous sample FIFO (power-of-2 depth); a pop frees space for a push in the same cycle.
module eq_sample_fifo #(
    parameter int DATA_BITS = 16,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 full,
    output logic                 empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_BITS-1:0] mem_r [DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [AW:0]          count_r;
    logic                 do_push_s;
    logic                 do_pop_s;

    assign full  = (count_r == (AW+1)'(DEPTH));
    assign empty = (count_r == {(AW+1){1'b0}});
    assign dout  = mem_r[rd_ptr_r];

    // Qualify requests against the current occupancy.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
    end

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/eq_i2s_tx.sv
// Equalizer output serializer: mono sample duplicated into an I2S stereo frame toward the DAC.
// Define I2S_TX_LEFT_JUSTIFIED_EN for left-justified framing instead of standard I2S.
module eq_i2s_tx
    import eq_i2s_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int BCLK_HALF  = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] sample_in,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic                 i2s_bclk,
    output logic                 i2s_ws,
    output logic                 i2s_sd,
    output logic                 underrun,
    output logic                 overrun,
    input  logic                 clear_flags
);
    localparam int FB = frame_bits(DATA_BITS);
    localparam int CW = $clog2(FB);
    localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [CW-1:0] LAST_BIT  = CW'(FB - 1);
    localparam logic [CW-1:0] START_BIT = CW'(FB - 2);
    localparam logic [DW-1:0] DIV_LAST  = DW'(BCLK_HALF - 1);

    // Word select for the bit position about to be driven.
    function automatic logic ws_for(input logic [CW-1:0] n);
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
        return (n >= CW'(DATA_BITS));
`else
        return (n == LAST_BIT) || (n <= CW'(DATA_BITS - 2));
`endif
    endfunction

    state_t               state_r;
    state_t               state_next_s;
    logic [DW-1:0]        div_cnt_r;
    logic                 bclk_r;
    logic [CW-1:0]        bit_cnt_r;
    logic [FB-1:0]        frame_r;
    logic                 ws_r;
    logic                 sd_r;
    logic [DATA_BITS-1:0] last_r;
    logic                 underrun_r;
    logic                 overrun_r;

    logic                 run_s;
    logic                 wrap_s;
    logic                 fall_s;
    logic                 stop_s;
    logic                 load_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 drop_s;
    logic [CW-1:0]        bit_next_s;
    logic [CW-1:0]        sd_idx_s;
    logic [DATA_BITS-1:0] load_data_s;
    logic [DATA_BITS-1:0] fifo_dout_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;

    eq_sample_fifo #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (sample_in),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Bit timing strobes, frame-boundary decisions and FIFO handshakes.
    always_comb begin
        run_s       = (state_r == ST_RUN);
        wrap_s      = run_s && (div_cnt_r == DIV_LAST);
        fall_s      = wrap_s && bclk_r;
        bit_next_s  = (bit_cnt_r == LAST_BIT) ? {CW{1'b0}} : bit_cnt_r + CW'(1);
        // A stop is only taken once the final bit of the frame has been on the line for a full bclk.
        stop_s      = fall_s && (bit_cnt_r == LAST_BIT) && !enable;
        load_s      = fall_s && !stop_s && (bit_next_s == {CW{1'b0}});
        pop_s       = load_s && !fifo_empty_s;
        load_data_s = fifo_empty_s ? last_r : fifo_dout_s;
        push_s      = sample_valid && (!fifo_full_s || pop_s);
        drop_s      = sample_valid && fifo_full_s && !pop_s;
        sd_idx_s    = LAST_BIT - bit_next_s;
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable && !fifo_empty_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Bit clock divider; bclk parks low outside RUN so the first edge in RUN is a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= {DW{1'b0}};
            bclk_r    <= 1'b0;
        end else if (!run_s || stop_s) begin
            div_cnt_r <= {DW{1'b0}};
            bclk_r    <= 1'b0;
        end else if (wrap_s) begin
            div_cnt_r <= {DW{1'b0}};
            bclk_r    <= !bclk_r;
        end else begin
            div_cnt_r <= div_cnt_r + DW'(1);
        end
    end

    // Serial datapath, updated on bclk falls. Each start re-emits the final bit position first,
    // so the previous LSB precedes the new MSB and the MSB lands on the second fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_r <= START_BIT;
            frame_r   <= {FB{1'b0}};
            ws_r      <= 1'b1;
            sd_r      <= 1'b0;
            last_r    <= {DATA_BITS{1'b0}};
        end else if (stop_s) begin
            bit_cnt_r <= START_BIT;
        end else if (fall_s) begin
            bit_cnt_r <= bit_next_s;
            ws_r      <= ws_for(bit_next_s);
            if (load_s) begin
                frame_r <= {load_data_s, load_data_s};
                sd_r    <= load_data_s[DATA_BITS-1];
                last_r  <= load_data_s;
            end else begin
                sd_r    <= frame_r[sd_idx_s];
            end
        end
    end

    // Sticky status flags; a clear wins over a coincident set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else if (clear_flags) begin
            underrun_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            underrun_r <= underrun_r | (load_s && fifo_empty_s);
            overrun_r  <= overrun_r | drop_s;
        end
    end

    assign sample_ready = !fifo_full_s;
    assign i2s_bclk     = bclk_r;
    assign i2s_ws       = ws_r;
    assign i2s_sd       = sd_r;
    assign underrun     = underrun_r;
    assign overrun      = overrun_r;

endmodule

// File: tb/tb_eq_i2s_tx.sv
// Directed bench for eq_i2s_tx: captures sd/ws on bclk rises and checks frames, flags and resets.
module tb_eq_i2s_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        i2s_bclk;
    logic        i2s_ws;
    logic        i2s_sd;
    logic        underrun;
    logic        overrun;
    logic        clear_flags;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic prev_bclk = 1'b0;
    logic sd_q[$];
    logic ws_q[$];
    int   rise_q[$];
    logic [15:0] vec [4];

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    localparam logic [31:0] WS_EXP = 32'h0000FFFF;
    localparam logic        MID_WS = 1'b1;
`else
    localparam logic [31:0] WS_EXP = 32'hFFFE0001;
    localparam logic        MID_WS = 1'b0;
`endif

    eq_i2s_tx dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .i2s_bclk     (i2s_bclk),
        .i2s_ws       (i2s_ws),
        .i2s_sd       (i2s_sd),
        .underrun     (underrun),
        .overrun      (overrun),
        .clear_flags  (clear_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling clk edge, logging line state at every bclk rise.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (i2s_bclk === 1'b1 && prev_bclk === 1'b0) begin
            sd_q.push_back(i2s_sd);
            ws_q.push_back(i2s_ws);
            rise_q.push_back(cyc);
        end
        prev_bclk = i2s_bclk;
    endtask

    task automatic clear_q();
        sd_q.delete();
        ws_q.delete();
        rise_q.delete();
    endtask

    // Strobe vec[k] every 64 clk and drop enable at cycle stop_at.
    task automatic run_stream(input int c_from, input int c_to, input int nvec, input int stop_at);
        for (int c = c_from; c < c_to; c++) begin
            if (c == stop_at) enable = 1'b0;
            if ((c % 64) == 0 && (c / 64) < nvec) begin
                sample_valid = 1'b1;
                sample_in    = vec[c / 64];
            end else begin
                sample_valid = 1'b0;
            end
            step();
        end
        sample_valid = 1'b0;
    endtask

    // 32 captured bits starting at rise index base, first bit in the MSB.
    function automatic logic [31:0] word_at(input int base, input bit use_ws);
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < 32; i++) begin
            if (base + i < sd_q.size()) w = {w[30:0], (use_ws ? ws_q[base + i] : sd_q[base + i])};
            else w = {w[30:0], 1'bx};
        end
        return w;
    endfunction

    initial begin
        rst = 1'b1; enable = 1'b0; sample_in = 16'h0; sample_valid = 1'b0; clear_flags = 1'b0;
        step(); step();
        chk("rst_bclk", 64'(i2s_bclk), 64'd0);
        chk("rst_ws", 64'(i2s_ws), 64'd1);
        chk("rst_sd", 64'(i2s_sd), 64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_ready", 64'(sample_ready), 64'd1);
        rst = 1'b0;
        step();

        // Single sample 8001: repeats on underrun; enable dropped at bit_cnt 5 of frame 2.
        vec[0] = 16'h8001;
        enable = 1'b1;
        clear_q();
        run_stream(0, 40, 1, 80);
        chk("s1_no_underrun_yet", 64'(underrun), 64'd0);
        run_stream(40, 140, 1, 80);
        chk("s1_bclk_period", 64'(rise_q[3] - rise_q[2]), 64'd2);
        chk("s1_rise_count", 64'(rise_q.size()), 64'd66);
        chk("s1_frame0", 64'(word_at(2, 1'b0)), 64'h80018001);
        chk("s1_frame1", 64'(word_at(34, 1'b0)), 64'h80018001);
        chk("s1_ws_pattern", 64'(word_at(2, 1'b1)), 64'(WS_EXP));
        chk("s1_underrun", 64'(underrun), 64'd1);
        chk("s1_idle_bclk", 64'(i2s_bclk), 64'd0);
        chk("s1_idle_ws", 64'(i2s_ws), 64'd1);
        clear_flags = 1'b1; step(); clear_flags = 1'b0;
        chk("s1_clear", 64'(underrun), 64'd0);

        // Four samples at the frame rate: no underrun or overrun.
        vec[0] = 16'h0001; vec[1] = 16'h7FFF; vec[2] = 16'hFFFF; vec[3] = 16'h8000;
        enable = 1'b1;
        clear_q();
        run_stream(0, 300, 4, 220);
        chk("s2_rise_count", 64'(rise_q.size()), 64'd130);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("s2_frame%0d", k), 64'(word_at(2 + 32 * k, 1'b0)), 64'({vec[k], vec[k]}));
        end
        chk("s2_underrun", 64'(underrun), 64'd0);
        chk("s2_overrun", 64'(overrun), 64'd0);

        // Three back-to-back strobes while idle: third overflows and is never sent.
        sample_valid = 1'b1; sample_in = 16'h1234; step();
        chk("s3_ready_after1", 64'(sample_ready), 64'd1);
        sample_in = 16'hABCD; step();
        chk("s3_ready_after2", 64'(sample_ready), 64'd0);
        sample_in = 16'h5555; step();
        sample_valid = 1'b0;
        chk("s3_overrun", 64'(overrun), 64'd1);
        enable = 1'b1;
        clear_q();
        run_stream(0, 140, 0, 80);
        chk("s3_rise_count", 64'(rise_q.size()), 64'd66);
        chk("s3_frame0", 64'(word_at(2, 1'b0)), 64'h12341234);
        chk("s3_frame1", 64'(word_at(34, 1'b0)), 64'hABCDABCD);
        chk("s3_underrun", 64'(underrun), 64'd0);
        chk("s3_overrun_sticky", 64'(overrun), 64'd1);
        clear_flags = 1'b1; step(); clear_flags = 1'b0;
        chk("s3_overrun_clear", 64'(overrun), 64'd0);

        // Clear coincident with an overflow wins; the same overflow alone sets the flag.
        sample_valid = 1'b1; sample_in = 16'h0F0F; step();
        sample_in = 16'h2222; step();
        sample_in = 16'h3333; clear_flags = 1'b1; step();
        clear_flags = 1'b0;
        chk("s4_clear_priority", 64'(overrun), 64'd0);
        step();
        sample_valid = 1'b0;
        chk("s4_overrun_set", 64'(overrun), 64'd1);

        // Reset in the middle of a frame (bit_cnt 20 of sample 0F0F).
        enable = 1'b1;
        clear_q();
        for (int c = 0; c < 45; c++) begin
            if (c == 10) begin
                sample_valid = 1'b1;
                sample_in    = 16'h4444;
            end else begin
                sample_valid = 1'b0;
            end
            step();
        end
        sample_valid = 1'b0;
        chk("s5_mid_ws", 64'(i2s_ws), 64'(MID_WS));
        chk("s5_mid_sd", 64'(i2s_sd), 64'd1);
        chk("s5_full_before", 64'(sample_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("s5_rst_bclk", 64'(i2s_bclk), 64'd0);
        chk("s5_rst_ws", 64'(i2s_ws), 64'd1);
        chk("s5_rst_sd", 64'(i2s_sd), 64'd0);
        chk("s5_rst_overrun", 64'(overrun), 64'd0);
        chk("s5_rst_ready", 64'(sample_ready), 64'd1);
        step();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) step();
        chk("s5_empty_stays_idle", 64'(i2s_bclk), 64'd0);
        chk("s5_no_rises", 64'(rise_q.size()), 64'd22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
